// File: rtl/fadd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pkg
// Summary  : Flag indices and field helpers for the parametrised FP adder.
// Revision : 1.0
// ============================================================================
package fadd_pkg;

    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    // Helpers take a zero-extended word plus the format widths; callers size-cast the result.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t field_mask(input int n);
        return (word_t'(1) << n) - word_t'(1);
    endfunction

    function automatic logic fp_sign(input word_t x, input int ew, input int mw);
        return 1'(x >> (ew + mw));
    endfunction

    function automatic word_t fp_exp(input word_t x, input int ew, input int mw);
        return (x >> mw) & field_mask(ew);
    endfunction

    function automatic word_t fp_frac(input word_t x, input int ew, input int mw);
        return x & field_mask(mw) & field_mask(ew + mw);
    endfunction

    function automatic logic is_nan(input word_t x, input int ew, input int mw);
        return (fp_exp(x, ew, mw) == field_mask(ew)) && (fp_frac(x, ew, mw) != '0);
    endfunction

    function automatic logic is_snan(input word_t x, input int ew, input int mw);
        return is_nan(x, ew, mw) && (1'(x >> (mw - 1)) == 1'b0);
    endfunction

    function automatic logic is_inf(input word_t x, input int ew, input int mw);
        return (fp_exp(x, ew, mw) == field_mask(ew)) && (fp_frac(x, ew, mw) == '0);
    endfunction

    function automatic logic is_zero_ftz(input word_t x, input int ew, input int mw);
        return fp_exp(x, ew, mw) == '0;
    endfunction

    function automatic word_t qnan(input int ew, input int mw);
        return (field_mask(ew) << mw) | (word_t'(1) << (mw - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fadd_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fadd_lzc
// Summary  : Leading-zero counter with all-zero flag.
// Revision : 1.0
// ============================================================================
module fadd_lzc #(
    parameter  int WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count,
    output logic             o_zero
);

    // Highest set bit is visited last, so it determines the count.
    always_comb begin
        o_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
        end
    end

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe
// Summary  : Three-stage pipelined FP adder/subtractor, RNE, FTZ, valid/ready.
// Revision : 1.0
// ============================================================================
module fadd_pipe
    import fadd_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_d,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int CW = $clog2(SW + 1);
    localparam int EW = ((EXP_W > CW) ? EXP_W : CW) + 2;
    localparam logic [31:0]   C_MAX_SH  = 32'(MAN_W + 3);
    localparam logic [EW-1:0] C_EXP_INF = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  C_QNAN    = W'(qnan(EXP_W, MAN_W));

    logic r1_valid, r2_valid, r3_valid;
    logic w_en1, w_en2, w_en3;

    assign w_en3    = !r3_valid || out_ready;
    assign w_en2    = !r2_valid || w_en3;
    assign w_en1    = !r1_valid || w_en2;
    assign in_ready = w_en1;

    // ---------------- stage 1: unpack, order, align, add ----------------
    logic [W-1:0]     w_b;
    word_t            w_ax, w_bx;
    logic             w_sa, w_sb, w_za, w_zb, w_a_ge, w_sg, w_sticky;
    logic [EXP_W-1:0] w_ea, w_eb, w_eg, w_el, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [31:0]      w_shamt;
    logic [SW-1:0]    w_sig_g, w_sig_l, w_sig_l_al;
    logic [SW:0]      w_sum;

    assign w_b  = {in_b[W-1] ^ in_sub, in_b[W-2:0]};
    assign w_ax = word_t'(in_a);
    assign w_bx = word_t'(w_b);
    assign w_sa = fp_sign(w_ax, EXP_W, MAN_W);
    assign w_sb = fp_sign(w_bx, EXP_W, MAN_W);
    assign w_ea = EXP_W'(fp_exp(w_ax, EXP_W, MAN_W));
    assign w_eb = EXP_W'(fp_exp(w_bx, EXP_W, MAN_W));
    assign w_za = is_zero_ftz(w_ax, EXP_W, MAN_W);
    assign w_zb = is_zero_ftz(w_bx, EXP_W, MAN_W);
    assign w_fa = w_za ? '0 : MAN_W'(fp_frac(w_ax, EXP_W, MAN_W));
    assign w_fb = w_zb ? '0 : MAN_W'(fp_frac(w_bx, EXP_W, MAN_W));

    assign w_a_ge  = {w_ea, w_fa} >= {w_eb, w_fb};
    assign w_sg    = w_a_ge ? w_sa : w_sb;
    assign w_eg    = w_a_ge ? w_ea : w_eb;
    assign w_el    = w_a_ge ? w_eb : w_ea;
    assign w_sig_g = w_a_ge ? {~w_za, w_fa, 3'b000} : {~w_zb, w_fb, 3'b000};
    assign w_sig_l = w_a_ge ? {~w_zb, w_fb, 3'b000} : {~w_za, w_fa, 3'b000};

    assign w_diff     = w_eg - w_el;
    assign w_shamt    = (32'(w_diff) > C_MAX_SH) ? C_MAX_SH : 32'(w_diff);
    assign w_sticky   = |(w_sig_l & ((SW'(1) << w_shamt) - SW'(1)));
    assign w_sig_l_al = (w_sig_l >> w_shamt) | SW'(w_sticky);
    assign w_sum      = (w_sa ^ w_sb) ? ({1'b0, w_sig_g} - {1'b0, w_sig_l_al})
                                      : ({1'b0, w_sig_g} + {1'b0, w_sig_l_al});

    logic         w_nan_any, w_snan_any, w_inf_a, w_inf_b, w_spec;
    logic [W-1:0] w_spec_res;
    logic [2:0]   w_spec_flags;

    assign w_nan_any  = is_nan(w_ax, EXP_W, MAN_W) || is_nan(w_bx, EXP_W, MAN_W);
    assign w_snan_any = is_snan(w_ax, EXP_W, MAN_W) || is_snan(w_bx, EXP_W, MAN_W);
    assign w_inf_a    = is_inf(w_ax, EXP_W, MAN_W);
    assign w_inf_b    = is_inf(w_bx, EXP_W, MAN_W);

    always_comb begin
        w_spec       = 1'b1;
        w_spec_res   = C_QNAN;
        w_spec_flags = '0;
        if (w_nan_any)                             w_spec_flags[FLAG_INV] = w_snan_any;
        else if (w_inf_a && w_inf_b && (w_sa != w_sb)) w_spec_flags[FLAG_INV] = 1'b1;
        else if (w_inf_a)                          w_spec_res = in_a;
        else if (w_inf_b)                          w_spec_res = w_b;
        else                                       w_spec = 1'b0;
    end

    logic             r1_sign, r1_spec, r1_zsign;
    logic [EXP_W-1:0] r1_exp;
    logic [SW:0]      r1_sum;
    logic [W-1:0]     r1_spec_res;
    logic [2:0]       r1_spec_flags;
    logic [TAG_W-1:0] r1_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_valid <= 1'b0; r1_sign <= 1'b0; r1_spec <= 1'b0; r1_zsign <= 1'b0;
            r1_exp <= '0; r1_sum <= '0; r1_spec_res <= '0; r1_spec_flags <= '0; r1_tag <= '0;
        end else if (w_en1) begin
            r1_valid      <= in_valid;
            r1_sign       <= w_sg;
            r1_spec       <= w_spec;
            r1_zsign      <= w_sa & w_sb;
            r1_exp        <= w_eg;
            r1_sum        <= w_sum;
            r1_spec_res   <= w_spec_res;
            r1_spec_flags <= w_spec_flags;
            r1_tag        <= in_tag;
        end
    end

    // ---------------- stage 2: normalise ----------------
    logic [CW-1:0] w_lz;
    logic          w_allz;
    logic [SW-1:0] w_norm;
    logic [EW-1:0] w_exp2;

    fadd_lzc #(.WIDTH(SW)) u_lzc (
        .i_data  (r1_sum[SW-1:0]),
        .o_count (w_lz),
        .o_zero  (w_allz)
    );

    always_comb begin
        if (r1_sum[SW]) begin
            w_norm = {r1_sum[SW:2], r1_sum[1] | r1_sum[0]};
            w_exp2 = EW'(r1_exp) + EW'(1);
        end else begin
            w_norm = r1_sum[SW-1:0] << w_lz;
            w_exp2 = EW'(r1_exp) - EW'(w_lz);
        end
    end

    logic             r2_sign, r2_spec, r2_zsign, r2_zero;
    logic [EW-1:0]    r2_exp;
    logic [SW-1:0]    r2_norm;
    logic [W-1:0]     r2_spec_res;
    logic [2:0]       r2_spec_flags;
    logic [TAG_W-1:0] r2_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r2_valid <= 1'b0; r2_sign <= 1'b0; r2_spec <= 1'b0; r2_zsign <= 1'b0; r2_zero <= 1'b0;
            r2_exp <= '0; r2_norm <= '0; r2_spec_res <= '0; r2_spec_flags <= '0; r2_tag <= '0;
        end else if (w_en2) begin
            r2_valid      <= r1_valid;
            r2_sign       <= r1_sign;
            r2_spec       <= r1_spec;
            r2_zsign      <= r1_zsign;
            r2_zero       <= w_allz && !r1_sum[SW];
            r2_exp        <= w_exp2;
            r2_norm       <= w_norm;
            r2_spec_res   <= r1_spec_res;
            r2_spec_flags <= r1_spec_flags;
            r2_tag        <= r1_tag;
        end
    end

    // ---------------- stage 3: round, specials, output ----------------
    logic             w_inc;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_frac3;
    logic [EW-1:0]    w_exp3;
    logic [W-1:0]     w_res;
    logic [2:0]       w_flags;

    assign w_inc   = r2_norm[2] && (r2_norm[1] || r2_norm[0] || r2_norm[3]);
    assign w_rnd   = {1'b0, r2_norm[SW-1:3]} + (MAN_W+2)'(w_inc);
    assign w_frac3 = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_exp3  = r2_exp + EW'(w_rnd[MAN_W+1]);

    always_comb begin
        w_res   = {r2_sign, w_exp3[EXP_W-1:0], w_frac3};
        w_flags = '0;
        if (r2_spec) begin
            w_res   = r2_spec_res;
            w_flags = r2_spec_flags;
        end else if (r2_zero) begin
            w_res   = {r2_zsign, {(W-1){1'b0}}};
        end else if ($signed(w_exp3) >= $signed(C_EXP_INF)) begin
            w_res             = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[FLAG_OVF] = 1'b1;
        end else if (w_exp3[EW-1] || (w_exp3 == '0)) begin
            w_res             = {r2_sign, {(W-1){1'b0}}};
            w_flags[FLAG_UNF] = 1'b1;
        end
    end

    logic [W-1:0]     r3_d;
    logic [TAG_W-1:0] r3_tag;
    logic [2:0]       r3_flags;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r3_valid <= 1'b0; r3_d <= '0; r3_tag <= '0; r3_flags <= '0;
        end else if (w_en3) begin
            r3_valid <= r2_valid;
            r3_d     <= w_res;
            r3_tag   <= r2_tag;
            r3_flags <= w_flags;
        end
    end

    assign out_valid = r3_valid;
    assign out_d     = r3_d;
    assign out_tag   = r3_tag;
    assign out_flags = r3_flags;

endmodule
`default_nettype wire

// File: tb/tb_fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_pipe
// Summary  : Scoreboard bench for fadd_pipe (binary32 and binary16 instances).
// Revision : 1.0
// ============================================================================
module tb_fadd_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_d;
    logic [3:0]  in_tag, out_tag;
    logic [2:0]  out_flags;

    logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_d;
    logic [3:0]  h_in_tag, h_out_tag;
    logic [2:0]  h_out_flags;

    fadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    fadd_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rstn(rstn), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_d(h_out_d),
        .out_tag(h_out_tag), .out_flags(h_out_flags)
    );

    typedef struct {
        logic [31:0] d;
        logic [2:0]  f;
        logic [3:0]  tag;
        bit          lat;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t hq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   saw_block = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [3:0] tag, input logic [31:0] ed, input logic [2:0] ef,
                         input bit lat);
        int k;
        exp_t e;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
        #1;
        while (!in_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (!in_ready) begin
            check("issue_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            e.d = ed; e.f = ef; e.tag = tag; e.lat = lat; e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic issue_h(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] ed, input logic [2:0] ef);
        exp_t e;
        @(negedge clk);
        h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_sub = sub; h_in_tag = 4'(hq.size());
        #1;
        e.d = {16'd0, ed}; e.f = ef; e.tag = h_in_tag; e.lat = 1'b1; e.cyc = cyc;
        hq.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b0; h_in_valid = 1'b0;
        while ((q.size() != 0 || hq.size() != 0) && k < 100) begin
            @(negedge clk); k++;
        end
        check("drain_q", q.size(), 0);
        check("drain_hq", hq.size(), 0);
    endtask

    // binary32 monitor: pops on every output transfer, checks stall stability
    initial begin
        exp_t        e;
        bit          stall_p;
        logic [31:0] st_d;
        logic [3:0]  st_t;
        logic [2:0]  st_f;
        stall_p = 0; st_d = '0; st_t = '0; st_f = '0;
        forever begin
            @(negedge clk); #2;
            if (!rstn) begin
                stall_p = 0;
                continue;
            end
            if (in_valid && !in_ready) saw_block = 1;
            if (stall_p) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_d", out_d, st_d);
                check("stall_tag", {28'd0, out_tag}, {28'd0, st_t});
                check("stall_flags", {29'd0, out_flags}, {29'd0, st_f});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: got %h tag %0d, required no output", out_d, out_tag);
                end else begin
                    e = q.pop_front();
                    check($sformatf("d_tag%0d", e.tag), out_d, e.d);
                    check($sformatf("flags_tag%0d", e.tag), {29'd0, out_flags}, {29'd0, e.f});
                    check("tag_order", {28'd0, out_tag}, {28'd0, e.tag});
                    if (e.lat) check("latency", cyc - e.cyc, 32'd3);
                end
            end
            stall_p = out_valid && !out_ready;
            st_d = out_d; st_t = out_tag; st_f = out_flags;
        end
    end

    // binary16 monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rstn && h_out_valid && h_out_ready) begin
                if (hq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL h_unexpected_out: got %h, required no output", h_out_d);
                end else begin
                    e = hq.pop_front();
                    check("h_d", {16'd0, h_out_d}, e.d);
                    check("h_flags", {29'd0, h_out_flags}, {29'd0, e.f});
                    check("h_tag", {28'd0, h_out_tag}, {28'd0, e.tag});
                    check("h_latency", cyc - e.cyc, 32'd3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_sub = 1'b0; h_in_tag = '0;
        h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_d", out_d, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_out_flags", {29'd0, out_flags}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // directed vectors, unstalled
        issue(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 3'b000, 1'b1);
        drain();
        issue(32'h3F800000, 32'h3F800000, 1'b1, 4'd2, 32'h00000000, 3'b000, 1'b1);
        issue(32'h80000000, 32'h80000000, 1'b0, 4'd3, 32'h80000000, 3'b000, 1'b1);
        issue(32'h3F800000, 32'h33800000, 1'b0, 4'd4, 32'h3F800000, 3'b000, 1'b1);
        issue(32'h3F800001, 32'h33800000, 1'b0, 4'd5, 32'h3F800002, 3'b000, 1'b1);
        issue(32'h3F800000, 32'h33800000, 1'b1, 4'd6, 32'h3F7FFFFF, 3'b000, 1'b1);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 4'd7, 32'h7FC00000, 3'b100, 1'b1);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd8, 32'h7F800000, 3'b010, 1'b1);
        issue(32'h00800001, 32'h00800000, 1'b1, 4'd9, 32'h00000000, 3'b001, 1'b1);
        issue(32'h7F800001, 32'h3F800000, 1'b0, 4'd10, 32'h7FC00000, 3'b100, 1'b1);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 4'd11, 32'h7FC00000, 3'b000, 1'b1);
        issue(32'h3F800000, 32'hFF800000, 1'b0, 4'd12, 32'hFF800000, 3'b000, 1'b1);
        issue(32'h00000001, 32'h3F800000, 1'b0, 4'd13, 32'h3F800000, 3'b000, 1'b1);
        issue(32'h3F800000, 32'h40000000, 1'b1, 4'd14, 32'hBF800000, 3'b000, 1'b1);
        issue(32'hBF800000, 32'hC0000000, 1'b0, 4'd15, 32'hC0400000, 3'b000, 1'b1);
        drain();

        // backpressure: out_ready low for cycles 4..7 of a 6-op burst
        fork
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd0, 32'h40000000, 3'b000, 1'b0);
                issue(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 3'b000, 1'b0);
                issue(32'h40000000, 32'h40000000, 1'b0, 4'd2, 32'h40800000, 3'b000, 1'b0);
                issue(32'h40400000, 32'h3F800000, 1'b0, 4'd3, 32'h40800000, 3'b000, 1'b0);
                issue(32'h40800000, 32'h3F800000, 1'b0, 4'd4, 32'h40A00000, 3'b000, 1'b0);
                issue(32'h40A00000, 32'h3F800000, 1'b1, 4'd5, 32'h40800000, 3'b000, 1'b0);
            end
        join
        drain();
        check("in_ready_dropped", {31'd0, saw_block}, 32'd1);

        // reset with three results in flight
        issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd10, 32'h40000000, 3'b000, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd11, 32'h40000000, 3'b000, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd12, 32'h40000000, 3'b000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_d", out_d, 32'd0);
        check("midrst_out_tag", {28'd0, out_tag}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        check("postrst_out_valid", {31'd0, out_valid}, 32'd0);

        // binary16 instance
        issue_h(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000);
        issue_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010);
        issue_h(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 3'b000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
